// File: rtl/vga_pkg.sv
// Shared definitions for the VGA line path: geometry defaults, RGB channel
// offsets, the line-buffer state type and the pixel index width helper.
package vga_pkg;

  localparam int PIXEL_DEPTH_DEF  = 4;
  localparam int SCREEN_WIDTH_DEF = 1000;
  localparam int CNT_WIDTH_DEF    = 8;

  // Channel slot within one packed pixel, counted from the LSB (blue lowest).
  localparam int RED_SLOT   = 2;
  localparam int GREEN_SLOT = 1;
  localparam int BLUE_SLOT  = 0;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } line_state_e;

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int rgb_offset(input int pixel_depth, input int slot);
    return pixel_depth * slot;
  endfunction

  localparam int IDX_W_DEF = idx_width(SCREEN_WIDTH_DEF);

endpackage

// File: rtl/scanline_builder.sv
// Packs a valid/ready pixel stream into a back line buffer and hands the
// finished line to the front buffer (scan_line) on each line_start pulse.
module scanline_builder
  import vga_pkg::*;
#(
  parameter int PIXEL_DEPTH  = PIXEL_DEPTH_DEF,
  parameter int SCREEN_WIDTH = SCREEN_WIDTH_DEF,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
  input  logic                                  clock_50mhz,
  input  logic                                  reset_n,
  input  logic                                  pix_valid,
  output logic                                  pix_ready,
  input  logic [3*PIXEL_DEPTH-1:0]              pix_rgb,
  input  logic                                  pix_last,
  input  logic                                  line_start,
  output logic [SCREEN_WIDTH*PIXEL_DEPTH*3-1:0] scan_line,
  output logic                                  line_ready,
  output logic [CNT_WIDTH-1:0]                  underrun_cnt,
  output logic                                  sync_error
);

  localparam int PW    = 3 * PIXEL_DEPTH;
  localparam int LW    = SCREEN_WIDTH * PW;
  localparam int IDX_W = idx_width(SCREEN_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SCREEN_WIDTH - 1);

  line_state_e          r_state;
  line_state_e          w_state_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [LW-1:0]        r_back;
  logic [LW-1:0]        r_front;
  logic [CNT_WIDTH-1:0] r_underrun;
  logic                 r_sync_err;

  logic w_accept;
  logic w_swap;
  logic w_underrun;
  logic w_at_last;
  logic w_close;

  // Handshake and line-event decode from the current state.
  always_comb begin
    w_accept   = 1'b0;
    w_swap     = 1'b0;
    w_underrun = 1'b0;
    w_at_last  = (r_idx == LAST_IDX);
    w_close    = 1'b0;
    if (r_state == ST_FILL) begin
      w_accept   = pix_valid;
      w_underrun = line_start;
      w_close    = pix_valid && (w_at_last || pix_last);
    end else begin
      w_swap = line_start;
    end
  end

  // Next-state logic for the fill/full handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: begin
        if (w_close) begin
          w_state_nxt = ST_FULL;
        end else begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_FULL: begin
        if (line_start) begin
          w_state_nxt = ST_FILL;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clock_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Back/front line buffers; the back buffer is cleared on swap so short lines pad with zero.
  always_ff @(posedge clock_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_back  <= {LW{1'b0}};
      r_front <= {LW{1'b0}};
    end else if (w_swap) begin
      r_front <= r_back;
      r_back  <= {LW{1'b0}};
    end else if (w_accept) begin
      for (int i = 0; i < SCREEN_WIDTH; i++) begin
        if (r_idx == IDX_W'(i)) begin
          r_back[i*PW +: PW] <= pix_rgb;
        end
      end
    end
  end

  // Write index, underrun counter and sticky length-mismatch flag.
  always_ff @(posedge clock_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_idx      <= {IDX_W{1'b0}};
      r_underrun <= {CNT_WIDTH{1'b0}};
      r_sync_err <= 1'b0;
    end else begin
      if (w_swap) begin
        r_idx <= {IDX_W{1'b0}};
      end else if (w_accept && !w_close) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_underrun && (r_underrun != {CNT_WIDTH{1'b1}})) begin
        r_underrun <= r_underrun + CNT_WIDTH'(1);
      end
      // Mismatch: pix_last early (short line) or missing at the last slot (long line).
      if (w_accept && (pix_last != w_at_last)) begin
        r_sync_err <= 1'b1;
      end
    end
  end

  assign pix_ready    = (r_state == ST_FILL);
  assign line_ready   = (r_state == ST_FULL);
  assign scan_line    = r_front;
  assign underrun_cnt = r_underrun;
  assign sync_error   = r_sync_err;

endmodule

// File: tb/tb_scanline_builder.sv
// Self-checking bench for scanline_builder: table vectors, directed corner
// sequences and randomized traffic against a queue-based line model.
module tb_scanline_builder;

  localparam int W  = 8;
  localparam int PD = 4;
  localparam int CW = 3;
  localparam int PW = 3 * PD;
  localparam int LW = W * PW;

  logic          clk;
  logic          reset_n;
  logic          pix_valid;
  logic          pix_ready;
  logic [PW-1:0] pix_rgb;
  logic          pix_last;
  logic          line_start;
  logic [LW-1:0] scan_line;
  logic          line_ready;
  logic [CW-1:0] underrun_cnt;
  logic          sync_error;

  scanline_builder #(
    .PIXEL_DEPTH (PD),
    .SCREEN_WIDTH(W),
    .CNT_WIDTH   (CW)
  ) dut (
    .clock_50mhz (clk),
    .reset_n     (reset_n),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_rgb     (pix_rgb),
    .pix_last    (pix_last),
    .line_start  (line_start),
    .scan_line   (scan_line),
    .line_ready  (line_ready),
    .underrun_cnt(underrun_cnt),
    .sync_error  (sync_error)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Line-level model: pixels of the line being built, the displayed line, counters.
  logic [PW-1:0] q[$];
  logic [PW-1:0] m_front[W];
  bit            m_full;
  int            m_cnt;
  bit            m_serr;

  typedef struct {
    logic          v;
    logic [PW-1:0] rgb;
    logic          l;
    logic          ls;
    logic          e_rdy;
    logic          e_lrdy;
    logic [LW-1:0] e_scan;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < W; i++) m_front[i] = '0;
    m_full = 1'b0;
    m_cnt  = 0;
    m_serr = 1'b0;
  endtask

  function automatic logic [LW-1:0] model_scan();
    logic [LW-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) r[i*PW +: PW] = m_front[i];
    return r;
  endfunction

  task automatic model_edge(input logic v, input logic [PW-1:0] rgb, input logic l, input logic ls);
    bit full_pre;
    full_pre = m_full;
    if (ls && full_pre) begin
      for (int i = 0; i < W; i++) m_front[i] = (i < q.size()) ? q[i] : '0;
      q.delete();
      m_full = 1'b0;
    end
    if (ls && !full_pre && m_cnt < (2 ** CW) - 1) m_cnt++;
    if (v && !full_pre) begin
      q.push_back(rgb);
      if (l || q.size() == W) m_full = 1'b1;
      if (l != (q.size() == W)) m_serr = 1'b1;
    end
  endtask

  task automatic compare_all();
    chk("pix_ready",    LW'(pix_ready),    LW'(!m_full));
    chk("line_ready",   LW'(line_ready),   LW'(m_full));
    chk("scan_line",    scan_line,         model_scan());
    chk("underrun_cnt", LW'(underrun_cnt), LW'(m_cnt));
    chk("sync_error",   LW'(sync_error),   LW'(m_serr));
  endtask

  // One clock: drive at negedge, model the edge, compare just after it.
  task automatic step(input logic v, input logic [PW-1:0] rgb, input logic l, input logic ls);
    pix_valid  = v;
    pix_rgb    = rgb;
    pix_last   = l;
    line_start = ls;
    @(posedge clk);
    model_edge(v, rgb, l, ls);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 12'h000, 1'b0, 1'b0);
  endtask

  task automatic feed(input logic [PW-1:0] first, input int n, input bit last_on_end);
    for (int i = 0; i < n; i++) begin
      step(1'b1, first + PW'(i), (last_on_end && (i == n - 1)) ? 1'b1 : 1'b0, 1'b0);
    end
  endtask

  logic [LW-1:0] saved;

  initial begin
    reset_n    = 1'b0;
    pix_valid  = 1'b0;
    pix_rgb    = 12'h000;
    pix_last   = 1'b0;
    line_start = 1'b0;
    model_reset();
    #1;
    chk("rst_pix_ready",  LW'(pix_ready),    LW'(1'b1));
    chk("rst_line_ready", LW'(line_ready),   LW'(1'b0));
    chk("rst_scan_line",  scan_line,         {LW{1'b0}});
    chk("rst_underrun",   LW'(underrun_cnt), LW'(3'd0));
    chk("rst_sync_error", LW'(sync_error),   LW'(1'b0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Table: a full line 0x001..0x008 with pix_last, then the swap.
    for (int i = 0; i < 8; i++) begin
      tbl[i].v      = 1'b1;
      tbl[i].rgb    = 12'(i + 1);
      tbl[i].l      = (i == 7) ? 1'b1 : 1'b0;
      tbl[i].ls     = 1'b0;
      tbl[i].e_rdy  = (i == 7) ? 1'b0 : 1'b1;
      tbl[i].e_lrdy = (i == 7) ? 1'b1 : 1'b0;
      tbl[i].e_scan = '0;
    end
    tbl[8] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 96'h008007006005004003002001};
    tbl[9] = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 96'h008007006005004003002001};
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].rgb, tbl[i].l, tbl[i].ls);
      chk("tbl_ready",      LW'(pix_ready),  LW'(tbl[i].e_rdy));
      chk("tbl_line_ready", LW'(line_ready), LW'(tbl[i].e_lrdy));
      chk("tbl_scan",       scan_line,       tbl[i].e_scan);
    end

    // Backpressure: line full, 9th pixel held for 5 cycles, accepted after the swap.
    feed(12'h101, 8, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 12'h1FF, 1'b0, 1'b0);
      chk("hold_pix_ready", LW'(pix_ready), LW'(1'b0));
    end
    step(1'b1, 12'h1FF, 1'b0, 1'b1);
    chk("hold_swap_scan", scan_line, 96'h108107106105104103102101);
    step(1'b1, 12'h1FF, 1'b0, 1'b0);
    feed(12'h202, 7, 1'b1);
    step(1'b0, 12'h000, 1'b0, 1'b1);
    chk("hold_first_pix", scan_line, 96'h2082072062052042032021FF);

    // Underrun mid-fill, then line_start coinciding with the final pixel.
    saved = scan_line;
    feed(12'h301, 3, 1'b0);
    step(1'b0, 12'h000, 1'b0, 1'b1);
    chk("underrun_scan_kept", scan_line,         saved);
    chk("underrun_one",       LW'(underrun_cnt), LW'(3'd1));
    feed(12'h304, 4, 1'b0);
    step(1'b1, 12'h308, 1'b1, 1'b1);
    chk("coincide_underrun",  LW'(underrun_cnt), LW'(3'd2));
    chk("coincide_full",      LW'(line_ready),   LW'(1'b1));
    chk("coincide_scan_kept", scan_line,         saved);
    step(1'b0, 12'h000, 1'b0, 1'b1);
    chk("underrun_line", scan_line, 96'h308307306305304303302301);

    // Short line: pix_last on the third pixel, remainder padded with zero.
    step(1'b1, 12'hAAA, 1'b0, 1'b0);
    step(1'b1, 12'hBBB, 1'b0, 1'b0);
    step(1'b1, 12'hCCC, 1'b1, 1'b0);
    step(1'b0, 12'h000, 1'b0, 1'b1);
    chk("short_scan", scan_line,       96'h000000000000000CCCBBBAAA);
    chk("short_serr", LW'(sync_error), LW'(1'b1));

    // Asynchronous reset mid-fill with non-zero front buffer.
    feed(12'h401, 5, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_scan",      scan_line,         {LW{1'b0}});
    chk("arst_ready",     LW'(pix_ready),    LW'(1'b1));
    chk("arst_underrun",  LW'(underrun_cnt), LW'(3'd0));
    chk("arst_serr",      LW'(sync_error),   LW'(1'b0));
    @(negedge clk);
    reset_n = 1'b1;
    feed(12'h501, 8, 1'b1);
    step(1'b0, 12'h000, 1'b0, 1'b1);
    chk("arst_refill", scan_line, 96'h508507506505504503502501);

    // Long line: no pix_last on the 8th pixel closes the line and flags it.
    feed(12'h601, 8, 1'b0);
    chk("long_serr",  LW'(sync_error), LW'(1'b1));
    chk("long_full",  LW'(line_ready), LW'(1'b1));
    step(1'b1, 12'h6FF, 1'b0, 1'b1);
    chk("long_scan",  scan_line, 96'h608607606605604603602601);

    // Counter saturation.
    for (int i = 0; i < 9; i++) step(1'b0, 12'h000, 1'b0, 1'b1);
    chk("underrun_sat", LW'(underrun_cnt), LW'(3'd7));

    // Randomized traffic against the model.
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           12'($urandom),
           ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0);
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/scanline_builder.md
Name: scanline_builder

Overview:
- Upstream neighbour of vga_interface. Accepts a pixel stream (valid/ready) and packs one display line into a back buffer.
- On the line-start pulse from the timing side, transfers the completed back buffer to the flat scan_line bus consumed by vga_interface.
- Ping-pong (back/front) line buffering, so vga_interface never sees a partially written line.

Parameters:
- PIXEL_DEPTH, 4, bits per colour channel.
- SCREEN_WIDTH, 1000, pixels per line (800 visible + 200 blanking, matching the scan_line width of vga_interface).
- CNT_WIDTH, 8, width of the saturating underrun counter.

Ports:
- clock_50mhz  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- pix_valid  in  1  pix_rgb/pix_last valid this cycle.
- pix_ready  out  1  builder can accept a pixel this cycle.
- pix_rgb  in  3*PIXEL_DEPTH  {red, green, blue}; red in the MSBs.
- pix_last  in  1  marks the final pixel of a line.
- line_start  in  1  single-cycle pulse from timing: present the next line now.
- scan_line  out  SCREEN_WIDTH*PIXEL_DEPTH*3  front buffer; pixel i occupies bits [(i+1)*3*PD-1 : i*3*PD], red/green/blue from high to low.
- line_ready  out  1  back buffer complete and waiting for swap.
- underrun_cnt  out  CNT_WIDTH  saturating count of swaps missed.
- sync_error  out  1  sticky: line length disagreed with pix_last.

Behaviour:
- Reset (asynchronous, active-low):
  - front and back buffers are all zero; scan_line is 0.
  - write index is 0; state is FILL.
  - pix_ready is 1; line_ready is 0; underrun_cnt is 0; sync_error is 0.
- States: FILL and FULL. pix_ready = (state==FILL); line_ready = (state==FULL). Both are combinational from the state register.
- Accept: pix_valid & pix_ready at a rising edge. The pixel is written to back[index].
  - If index==SCREEN_WIDTH-1 or pix_last=1: go to FULL.
  - Otherwise: index increments.
- Length checks:
  - pix_last with index<SCREEN_WIDTH-1 (short line): set sync_error. Unwritten pixels stay zero, because the back buffer is cleared at every swap.
  - index==SCREEN_WIDTH-1 without pix_last (long line): set sync_error. The line closes anyway, and subsequent pixels belong to the next line.
- Swap (line_start=1 at an edge while state==FULL), all in the same edge:
  - front <= back; back <= 0; index <= 0; state <= FILL.
- Underrun (line_start=1 while state==FILL):
  - front is unchanged and the previous line repeats.
  - back and index are untouched, and filling continues.
  - underrun_cnt increments and saturates at all-ones.
- Simultaneous line_start with the final pixel accept: the state register is still FILL, so this counts as an underrun. The pixel is written, state goes to FULL, and the swap happens on the next line_start.
- Latency: a pixel accepted at edge N appears on scan_line after the first edge at or after N+1 where line_start=1 and state==FULL. scan_line changes only on swap edges.
- In FULL, pix_ready=0. The upstream source holds pix_valid and its data; no data is dropped.
- line_start pulses longer than one cycle: each high cycle is evaluated independently.
- sync_error clears only on reset.
- Reset mid-line: all partial content is discarded and the buffers return to zero. There is no glitch handling beyond async assertion.
- Clock-domain note: line_start must be synchronous to clock_50mhz.

Decomposition:
- Shared package vga_pkg:
  - PIXEL_DEPTH and SCREEN_WIDTH defaults.
  - RGB slice offsets.
  - Two-value state type {FILL, FULL}.
  - Pixel index width, computed as clog2(SCREEN_WIDTH).
- No sub-module. A single always block for the buffers plus one for state/counters is sufficient.

Test Plan:
- Reset release, SCREEN_WIDTH=8, PD=4 -> pix_ready=1, line_ready=0, scan_line=0, underrun_cnt=0.
- Stream pixels 0x001..0x008 with pix_last on the 8th, then pulse line_start -> next cycle scan_line=0x008_007_006_005_004_003_002_001, pix_ready=1, line_ready=0.
- Fill 8 pixels, hold pix_valid for a 9th while waiting 5 cycles -> pix_ready=0 throughout. The 9th pixel is accepted only on the cycle after the swap, as back[0].
- line_start pulse at index 3 (FILL) -> scan_line unchanged, underrun_cnt=1. After the remaining 5 pixels and the next line_start, the full line appears.
- pix_last on the 3rd pixel (0xAAA,0xBBB,0xCCC) then swap -> pixels 0..2 hold those values, pixels 3..7 are 0, sync_error=1.
- Assert reset_n=0 mid-fill (index 5) with front non-zero -> scan_line=0 immediately (async). After release, the next fill starts at index 0.
